load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 230 +++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Byte-serial load/store engine that sits between a pipeline and a data
// memory that can only move a single byte per cycle. An access of N bytes
// (N = 1, 2, 4 or 8, taken from funct3[1:0]) is split into N consecutive
// byte cycles at addr, addr+1, ... (the address wraps at all-ones). For
// loads, each returned byte is collected into the result and then sign- or
// zero-extended.
//
// Ports
//   clk, rst           single clock; asynchronous active-high reset
//   req_valid/ready    request handshake; ready only while idle
//   req_we             1 store, 0 load
//   req_addr           byte address, any alignment
//   req_funct3         [1:0] size (B/H/W/D), [2] unsigned load
//   req_store_data     store data, least significant byte first
//   resp_valid/ready   response handshake
//   resp_data          extended load result (0 for stores and errors)
//   resp_err           illegal funct3 (store with [2]=1, or 3'b111)
//   mem_we             byte write enable, written at the clk edge
//   mem_addr           byte address presented to memory
//   mem_funct3         SB while storing, LBU otherwise
//   mem_store_data     byte in [7:0], upper bits zero
//   mem_load_data      zero-extended byte at mem_addr (combinational)
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int DWORD_BITS  = 64,
  parameter int FUNCT3_BITS = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [DWORD_BITS-1:0]  req_addr,
  input  logic [FUNCT3_BITS-1:0] req_funct3,
  input  logic [DWORD_BITS-1:0]  req_store_data,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [DWORD_BITS-1:0]  resp_data,
  output logic                   resp_err,
  output logic                   mem_we,
  output logic [DWORD_BITS-1:0]  mem_addr,
  output logic [FUNCT3_BITS-1:0] mem_funct3,
  output logic [DWORD_BITS-1:0]  mem_store_data,
  input  logic [DWORD_BITS-1:0]  mem_load_data
);

  localparam int BYTES  = DWORD_BITS / 8;
  localparam int K_BITS = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [FUNCT3_BITS-1:0] F3_SB  = FUNCT3_BITS'(3'b000);
  localparam logic [FUNCT3_BITS-1:0] F3_LBU = FUNCT3_BITS'(3'b100);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                 state_reg;
  logic [K_BITS-1:0]      k_reg;
  logic [K_BITS-1:0]      last_k_reg;
  logic                   we_reg;
  logic                   unsigned_reg;
  logic [1:0]             size_reg;
  logic [DWORD_BITS-1:0]  store_data_reg;
  logic [DWORD_BITS-1:0]  load_buf_reg;

  logic                   req_ready_reg;
  logic                   resp_valid_reg;
  logic                   resp_err_reg;
  logic [DWORD_BITS-1:0]  resp_data_reg;
  logic                   mem_we_reg;
  logic [DWORD_BITS-1:0]  mem_addr_reg;
  logic [FUNCT3_BITS-1:0] mem_funct3_reg;
  logic [DWORD_BITS-1:0]  mem_store_data_reg;

  logic                   req_illegal;
  logic [K_BITS-1:0]      req_last_k;
  logic [K_BITS-1:0]      k_next;
  logic [DWORD_BITS-1:0]  load_assembled;
  logic [DWORD_BITS-1:0]  load_result;

  // Memory only ever returns a zero-extended byte; the upper lanes carry
  // nothing of interest.
  logic                   unused_load_bits;
  assign unused_load_bits = ^mem_load_data[DWORD_BITS-1:8];

  assign req_ready      = req_ready_reg;
  assign resp_valid     = resp_valid_reg;
  assign resp_err       = resp_err_reg;
  assign resp_data      = resp_data_reg;
  assign mem_we         = mem_we_reg;
  assign mem_addr       = mem_addr_reg;
  assign mem_funct3     = mem_funct3_reg;
  assign mem_store_data = mem_store_data_reg;

  // Stores have no unsigned variant, and 3'b111 (unsigned doubleword) has
  // no meaning on a 64-bit datapath.
  assign req_illegal = (req_we && req_funct3[2]) || (req_funct3[2:0] == 3'b111);

  // Index of the final byte of the access.
  always_comb begin
    req_last_k = '0;
    case (req_funct3[1:0])
      2'd0:    req_last_k = K_BITS'(0);
      2'd1:    req_last_k = K_BITS'(1);
      2'd2:    req_last_k = K_BITS'(3);
      default: req_last_k = K_BITS'(7);
    endcase
  end

  assign k_next = k_reg + K_BITS'(1);

  // Merge the byte arriving this cycle into the bytes gathered so far, so
  // the final edge can produce the complete result without an extra cycle.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_lane
      assign load_assembled[8*gi +: 8] = (k_reg == K_BITS'(gi)) ? mem_load_data[7:0]
                                                                  : load_buf_reg[8*gi +: 8];
    end
  endgenerate

  // Extend from the top bit of the loaded size; doubleword is already full.
  always_comb begin
    load_result = load_assembled;
    case (size_reg)
      2'd0: load_result = {{(DWORD_BITS-8){~unsigned_reg & load_assembled[7]}},
                           load_assembled[7:0]};
      2'd1: load_result = {{(DWORD_BITS-16){~unsigned_reg & load_assembled[15]}},
                           load_assembled[15:0]};
      2'd2: load_result = {{(DWORD_BITS-32){~unsigned_reg & load_assembled[31]}},
                           load_assembled[31:0]};
      default: load_result = load_assembled;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg          <= IDLE;
      k_reg              <= '0;
      last_k_reg         <= '0;
      we_reg             <= 1'b0;
      unsigned_reg       <= 1'b0;
      size_reg           <= 2'd0;
      store_data_reg     <= '0;
      load_buf_reg       <= '0;
      req_ready_reg      <= 1'b1;
      resp_valid_reg     <= 1'b0;
      resp_err_reg       <= 1'b0;
      resp_data_reg      <= '0;
      mem_we_reg         <= 1'b0;
      mem_addr_reg       <= '0;
      mem_funct3_reg     <= F3_LBU;
      mem_store_data_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            req_ready_reg  <= 1'b0;
            we_reg         <= req_we;
            unsigned_reg   <= req_funct3[2];
            size_reg       <= req_funct3[1:0];
            last_k_reg     <= req_last_k;
            k_reg          <= '0;
            store_data_reg <= req_store_data;
            load_buf_reg   <= '0;
            if (req_illegal) begin
              // Rejected without touching memory.
              state_reg      <= DONE;
              resp_valid_reg <= 1'b1;
              resp_err_reg   <= 1'b1;
              resp_data_reg  <= '0;
            end else begin
              // First byte goes out on the cycle right after the accept.
              state_reg          <= ACCESS;
              mem_we_reg         <= req_we;
              mem_addr_reg       <= req_addr;
              mem_funct3_reg     <= req_we ? F3_SB : F3_LBU;
              mem_store_data_reg <= req_we ? DWORD_BITS'(req_store_data[7:0]) : '0;
            end
          end
        end

        ACCESS: begin
          load_buf_reg <= load_assembled;
          if (k_reg == last_k_reg) begin
            state_reg          <= DONE;
            k_reg              <= '0;
            resp_valid_reg     <= 1'b1;
            resp_err_reg       <= 1'b0;
            resp_data_reg      <= we_reg ? '0 : load_result;
            mem_we_reg         <= 1'b0;
            mem_addr_reg       <= '0;
            mem_funct3_reg     <= F3_LBU;
            mem_store_data_reg <= '0;
          end else begin
            k_reg        <= k_next;
            // Plain modular increment gives the wrap at all-ones.
            mem_addr_reg <= mem_addr_reg + DWORD_BITS'(1);
            if (we_reg) begin
              mem_store_data_reg <= DWORD_BITS'(store_data_reg[{k_next, 3'b000} +: 8]);
            end
          end
        end

        DONE: begin
          // The consuming edge only returns to IDLE; a request present on
          // that edge is taken on a later one.
          if (resp_ready) begin
            state_reg      <= IDLE;
            req_ready_reg  <= 1'b1;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_data_reg  <= '0;
          end
        end

        default: begin
          state_reg     <= IDLE;
          req_ready_reg <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [2:0]  req_funct3;
  logic [63:0] req_store_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_data;
  logic        resp_err;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [2:0]  mem_funct3;
  logic [63:0] mem_store_data;
  logic [63:0] mem_load_data;

  int compared   = 0;
  int mismatched = 0;

  // Environment memory (written by the DUT) and the reference image the
  // bench maintains from the transactions it issues. Both alias on the low
  // 12 address bits, identically.
  logic [7:0] mem     [0:4095] = '{default: 8'h00};
  logic [7:0] ref_mem [0:4095] = '{default: 8'h00};

  load_store_unit #(
    .DWORD_BITS (64),
    .FUNCT3_BITS(3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_funct3    (req_funct3),
    .req_store_data(req_store_data),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_data     (resp_data),
    .resp_err      (resp_err),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_funct3    (mem_funct3),
    .mem_store_data(mem_store_data),
    .mem_load_data (mem_load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[11:0]] <= mem_store_data[7:0];
  end
  assign mem_load_data = {56'd0, mem[mem_addr[11:0]]};

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected load value from the reference image: gather N bytes
  // little-endian, then extend arithmetically from bit 8N-1.
  function automatic logic [63:0] model_load(input logic [63:0] addr, input logic [2:0] f3);
    int          n;
    logic [63:0] v;
    logic [63:0] a;
    n = 1 << f3[1:0];
    v = 64'd0;
    for (int i = 0; i < n; i++) begin
      a = addr + 64'(i);
      v = v | (64'(ref_mem[a[11:0]]) << (8 * i));
    end
    if (!f3[2] && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
    return v;
  endfunction

  task automatic drive_junk();
    req_we         = 1'($urandom);
    req_addr       = {$urandom, $urandom};
    req_funct3     = 3'($urandom);
    req_store_data = {$urandom, $urandom};
  endtask

  task automatic check_mem_idle(input string tag);
    check({tag, "_mem_we"},    64'(mem_we), 64'd0);
    check({tag, "_mem_addr"},  mem_addr, 64'd0);
    check({tag, "_mem_f3"},    64'(mem_funct3), 64'd4);
    check({tag, "_mem_sdata"}, mem_store_data, 64'd0);
  endtask

  // One complete transaction, entered and left at #1 after a rising edge.
  // A junk request stays asserted while busy and across the consuming edge.
  task automatic do_txn(input logic we, input logic [63:0] addr, input logic [2:0] f3,
                        input logic [63:0] data, input int hold, output logic [63:0] got);
    logic        illegal;
    int          n;
    logic [63:0] exp_data;
    logic [63:0] a;
    illegal  = (f3 == 3'b111) || (we && f3[2]);
    n        = 1 << f3[1:0];
    exp_data = (we || illegal) ? 64'd0 : model_load(addr, f3);

    check("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid      = 1'b1;
    req_we         = we;
    req_addr       = addr;
    req_funct3     = f3;
    req_store_data = data;
    @(posedge clk); #1;
    drive_junk();
    resp_ready = 1'($urandom);

    if (!illegal) begin
      for (int k = 0; k < n; k++) begin
        a = addr + 64'(k);
        check("acc_mem_we",    64'(mem_we), 64'(we));
        check("acc_mem_addr",  mem_addr, a);
        check("acc_mem_f3",    64'(mem_funct3), we ? 64'd0 : 64'd4);
        check("acc_mem_sdata", mem_store_data, we ? 64'(data[8*k +: 8]) : 64'd0);
        check("acc_resp_valid", 64'(resp_valid), 64'd0);
        check("acc_req_ready",  64'(req_ready), 64'd0);
        if (we) ref_mem[a[11:0]] = data[8*k +: 8];
        @(posedge clk); #1;
        drive_junk();
        resp_ready = 1'($urandom);
      end
    end

    // Response is due N edges after the accept edge (N+1 cycles), or
    // directly after it for a rejected request.
    resp_ready = (hold == 0);
    check("resp_valid", 64'(resp_valid), 64'd1);
    check("resp_err",   64'(resp_err), 64'(illegal));
    check("resp_data",  resp_data, exp_data);
    check("done_req_ready", 64'(req_ready), 64'd0);
    check_mem_idle("done");
    got = resp_data;

    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      drive_junk();
      check("hold_resp_valid", 64'(resp_valid), 64'd1);
      check("hold_resp_data",  resp_data, exp_data);
      check("hold_resp_err",   64'(resp_err), 64'(illegal));
      check("hold_req_ready",  64'(req_ready), 64'd0);
      check("hold_mem_we",     64'(mem_we), 64'd0);
      resp_ready = (h == hold - 1);
    end

    @(posedge clk); #1;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    check("post_resp_valid", 64'(resp_valid), 64'd0);
    check("post_req_ready",  64'(req_ready), 64'd1);
    check("post_resp_data",  resp_data, 64'd0);
    check("post_resp_err",   64'(resp_err), 64'd0);
    check_mem_idle("post");
    $display("txn we=%0d addr=%h f3=%b data=%h resp=%h err=%0d hold=%0d",
             we, addr, f3, data, got, illegal, hold);
  endtask

  initial begin : stim
    logic [63:0] got;
    logic [63:0] sd_data;
    logic [63:0] a;
    logic        we;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] data;
    int          hold;
    int          diff;

    rst            = 1'b1;
    req_valid      = 1'b0;
    req_we         = 1'b0;
    req_addr       = 64'd0;
    req_funct3     = 3'd0;
    req_store_data = 64'd0;
    resp_ready     = 1'b0;

    // Reset state, observed before any clock edge.
    #3;
    check("rst_req_ready",  64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_err",   64'(resp_err), 64'd0);
    check("rst_resp_data",  resp_data, 64'd0);
    check_mem_idle("rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // SD at 0x1007: eight SB cycles, bytes FF..88.
    do_txn(1'b1, 64'h1007, 3'b011, 64'h8899AABBCCDDEEFF, 0, got);
    check("sd_resp_zero", got, 64'd0);
    check("sd_mem_1007", 64'(mem[12'h007]), 64'hFF);
    check("sd_mem_100e", 64'(mem[12'h00E]), 64'h88);

    do_txn(1'b0, 64'h1007, 3'b000, 64'd0, 1, got);
    check("lb_const", got, 64'hFFFFFFFFFFFFFFFF);
    do_txn(1'b0, 64'h1007, 3'b100, 64'd0, 0, got);
    check("lbu_const", got, 64'h00000000000000FF);
    do_txn(1'b0, 64'h100B, 3'b010, 64'd0, 0, got);
    check("lw_const", got, 64'hFFFFFFFF8899AABB);
    do_txn(1'b0, 64'h100B, 3'b110, 64'd0, 2, got);
    check("lwu_const", got, 64'h000000008899AABB);
    do_txn(1'b0, 64'h1007, 3'b011, 64'd0, 0, got);
    check("ld_const", got, 64'h8899AABBCCDDEEFF);

    // SH across the top of the address space.
    do_txn(1'b1, 64'hFFFFFFFFFFFFFFFF, 3'b001, 64'h1234, 0, got);
    check("sh_wrap_byte_hi", 64'(mem[12'hFFF]), 64'h34);
    check("sh_wrap_byte_lo", 64'(mem[12'h000]), 64'h12);
    do_txn(1'b0, 64'hFFFFFFFFFFFFFFFF, 3'b001, 64'd0, 0, got);
    check("lh_wrap_const", got, 64'h1234);

    // Rejected requests: store with unsigned bit, and funct3 3'b111 load.
    do_txn(1'b1, 64'h1010, 3'b100, 64'hDEAD, 3, got);
    check("err_store_mem_untouched", 64'(mem[12'h010]), 64'h00);
    do_txn(1'b0, 64'h1007, 3'b111, 64'd0, 0, got);

    // Reset during the third byte of an SD.
    sd_data = {$urandom, $urandom};
    check("rstmid_req_ready", 64'(req_ready), 64'd1);
    req_valid      = 1'b1;
    req_we         = 1'b1;
    req_addr       = 64'h200;
    req_funct3     = 3'b011;
    req_store_data = sd_data;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      a = 64'h200 + 64'(k);
      check("rstmid_mem_addr", mem_addr, a);
      check("rstmid_mem_we", 64'(mem_we), 64'd1);
      ref_mem[a[11:0]] = sd_data[8*k +: 8];
      @(posedge clk); #1;
    end
    check("rstmid_third_we",   64'(mem_we), 64'd1);
    check("rstmid_third_addr", mem_addr, 64'h202);
    rst = 1'b1;
    #1;
    check_mem_idle("rstmid_async");
    check("rstmid_req_ready_async",  64'(req_ready), 64'd1);
    check("rstmid_resp_valid_async", 64'(resp_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("rstmid_no_resp", 64'(resp_valid), 64'd0);
      check("rstmid_idle_we", 64'(mem_we), 64'd0);
      check("rstmid_ready",   64'(req_ready), 64'd1);
      @(posedge clk); #1;
    end
    check("rstmid_byte0", 64'(mem[12'h200]), 64'(sd_data[7:0]));
    check("rstmid_byte1", 64'(mem[12'h201]), 64'(sd_data[15:8]));
    check("rstmid_byte2", 64'(mem[12'h202]), 64'h00);
    check("rstmid_byte7", 64'(mem[12'h207]), 64'h00);
    $display("txn reset-abort sd addr=0000000000000200 data=%h", sd_data);
    do_txn(1'b0, 64'h200, 3'b011, 64'd0, 0, got);
    check("rstmid_ld_const", got, {48'd0, sd_data[15:0]});

    // Randomized traffic against the reference image.
    for (int t = 0; t < 40; t++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0:       addr = 64'h1000 + 64'($urandom_range(0, 63));
        1:       addr = 64'hFFFFFFFFFFFFFFF8 + 64'($urandom_range(0, 7));
        default: addr = {$urandom, $urandom};
      endcase
      data = {$urandom, $urandom};
      hold = $urandom_range(0, 2);
      do_txn(we, addr, f3, data, hold, got);
    end

    diff = 0;
    for (int i = 0; i < 4096; i++) begin
      if (mem[i] !== ref_mem[i]) diff++;
    end
    check("mem_image_diff_count", 64'(diff), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
